// File: rtl/part_2_event_capture.sv
`default_nettype none
// ============================================================================
//  Module   : part_2_event_capture
//  Purpose  : Upstream stage of the partition-2 initiator transport FSM.
//             Detects rising edges of the mission clock clk_0_h in the clk_i
//             domain. On each edge it snapshots {wen,data} for every channel,
//             tags the snapshot with a sequence number and queues it in a
//             FIFO. The FIFO head is handed out on a valid/ready handshake.
//             freeze_clk_o asks the mission clock generator to stall before
//             the queue overflows.
//  Ports    : clk_i, rst_n_i    utility clock, async active-low reset
//             clk_0_h           mission clock, sampled as async data
//             wen_i, data_i     partition outputs (NCH x {wen, 8-bit data})
//             vec_valid_o/vec_ready_i/vec_data_o/vec_seq_o  head handshake
//             level_o           FIFO occupancy
//             freeze_clk_o      mission clock freeze request
//             overflow_o        sticky: an edge was dropped
//             drop_cnt_o        saturating count of dropped edges
//             flush_i           synchronous FIFO clear
//  Option   : PART_2_CAPTURE_CHANGE_ONLY_EN - when defined, an edge is only
//             queued if its vector differs from the last accepted vector.
//  Revision : 1.0 - initial release
// ============================================================================
module part_2_event_capture #(
   parameter int NCH       = 3,
   parameter int DEPTH     = 8,
   parameter int FREEZE_HI = 6,
   parameter int FREEZE_LO = 2,
   parameter int SEQ_W     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     clk_0_h,
   input  logic [NCH-1:0]           wen_i,
   input  logic [NCH*8-1:0]         data_i,
   output logic                     vec_valid_o,
   input  logic                     vec_ready_i,
   output logic [NCH*9-1:0]         vec_data_o,
   output logic [SEQ_W-1:0]         vec_seq_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     freeze_clk_o,
   output logic                     overflow_o,
   output logic [7:0]               drop_cnt_o,
   input  logic                     flush_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int VW = NCH * 9;
   localparam int EW = VW + SEQ_W;

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] HI_L    = LW'(FREEZE_HI);
   localparam logic [LW-1:0] LO_L    = LW'(FREEZE_LO);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_FROZEN = 1'b1
   } frz_state_t;

   // edge detection
   logic s1, s2, s3;
   logic edge_det;

   // queue
   logic [EW-1:0]    mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level, level_nxt;
   logic [SEQ_W-1:0] seq;
   logic [VW-1:0]    cap_vec;
   logic [EW-1:0]    head;

   logic changed, push_req, pop, accept, drop;
   frz_state_t state;

   // snapshot packing: channel k = {wen[k], data[8k+7:8k]}
   for (genvar k = 0; k < NCH; k++) begin : g_pack
      assign cap_vec[9*k +: 9] = {wen_i[k], data_i[8*k +: 8]};
   end

   assign edge_det = s2 & ~s3;

`ifdef PART_2_CAPTURE_CHANGE_ONLY_EN
   logic [VW-1:0] last_vec;
   logic          seen;   // an entry has been accepted since reset

   assign changed = ~seen | (cap_vec != last_vec);

   // last accepted vector survives flush; only reset clears it
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_vec <= '0;
         seen     <= 1'b0;
      end else if (accept) begin
         last_vec <= cap_vec;
         seen     <= 1'b1;
      end
   end
`else
   assign changed = 1'b1;
`endif

   assign vec_valid_o = (level != '0);
   assign pop         = vec_valid_o & vec_ready_i & ~flush_i;
   assign push_req    = edge_det & changed & ~flush_i;
   // a simultaneous pop frees the slot the push needs
   assign accept      = push_req & ((level < DEPTH_L) | pop);
   assign drop        = push_req & ~accept;

   always_comb begin
      level_nxt = level;
      if (flush_i)
         level_nxt = '0;
      else if (accept & ~pop)
         level_nxt = level + LW'(1);
      else if (~accept & pop)
         level_nxt = level - LW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         seq        <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         s1    <= clk_0_h;
         s2    <= s1;
         s3    <= s2;
         level <= level_nxt;
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (accept) begin
               mem[wr_ptr] <= {seq, cap_vec};
               wr_ptr      <= wr_ptr + PW'(1);
               seq         <= seq + SEQ_W'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
         end
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 8'hFF)
               drop_cnt_o <= drop_cnt_o + 8'd1;
         end
      end
   end

   assign head       = mem[rd_ptr];
   assign vec_data_o = head[VW-1:0];
   assign vec_seq_o  = head[EW-1:VW];

   // freeze hysteresis, decided on the occupancy the FIFO is about to have
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= ST_RUN;
         freeze_clk_o <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!flush_i && level_nxt >= HI_L) begin
                  state        <= ST_FROZEN;
                  freeze_clk_o <= 1'b1;
               end
            end
            ST_FROZEN: begin
               if (flush_i || level_nxt <= LO_L) begin
                  state        <= ST_RUN;
                  freeze_clk_o <= 1'b0;
               end
            end
            default: begin
               state        <= ST_RUN;
               freeze_clk_o <= 1'b0;
            end
         endcase
      end
   end

   assign level_o = level;

endmodule
`default_nettype wire

// File: tb/tb_part_2_event_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_part_2_event_capture
//  Purpose  : Self-checking bench for part_2_event_capture: a directed vector
//             table, hand-written corner sequences and a randomized run
//             compared against a queue-based reference model.
//  Option   : PART_2_CAPTURE_CHANGE_ONLY_EN selects the change-only model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_part_2_event_capture;

   localparam int NCH   = 3;
   localparam int DEPTH = 8;
   localparam int HI    = 6;
   localparam int LO    = 2;
   localparam int VW    = NCH * 9;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic            clk_0_h = 1'b0;
   logic [2:0]      wen_i = '0;
   logic [23:0]     data_i = '0;
   logic            vec_ready_i = 1'b0;
   logic            flush_i = 1'b0;
   logic            vec_valid_o;
   logic [VW-1:0]   vec_data_o;
   logic [7:0]      vec_seq_o;
   logic [3:0]      level_o;
   logic            freeze_clk_o;
   logic            overflow_o;
   logic [7:0]      drop_cnt_o;

   part_2_event_capture dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clk_0_h      (clk_0_h),
      .wen_i        (wen_i),
      .data_i       (data_i),
      .vec_valid_o  (vec_valid_o),
      .vec_ready_i  (vec_ready_i),
      .vec_data_o   (vec_data_o),
      .vec_seq_o    (vec_seq_o),
      .level_o      (level_o),
      .freeze_clk_o (freeze_clk_o),
      .overflow_o   (overflow_o),
      .drop_cnt_o   (drop_cnt_o),
      .flush_i      (flush_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;
   int uniq   = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [VW-1:0] vec;
      logic [7:0]    seq;
   } ent_t;

   ent_t          mq[$];
   int            hist[$];     // clk_0_h as seen at each clk_i edge
   int            m_seq;
   bit            m_ovf;
   int            m_drop;
   bit            m_frz;
   logic [VW-1:0] m_last;
   bit            m_seen;

   function automatic logic [VW-1:0] pack_vec(input logic [2:0] w, input logic [23:0] d);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < NCH; k++)
         v[9*k +: 9] = {w[k], d[8*k +: 8]};
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      hist.delete();
      m_seq  = 0;
      m_ovf  = 0;
      m_drop = 0;
      m_frz  = 0;
      m_last = '0;
      m_seen = 0;
   endtask

   // advance the model by one clk_i edge using the inputs present before it
   task automatic model_step();
      int            n;
      bit            ev, want, do_pop;
      logic [VW-1:0] v;
      n  = hist.size();
      // a rise of clk_0_h becomes a push two clk_i edges after it is sampled
      ev = (n >= 2 && hist[n-2] == 1) && !(n >= 3 && hist[n-3] == 1);
      hist.push_back(int'(clk_0_h));
      if (hist.size() > 8) void'(hist.pop_front());
      do_pop = (mq.size() != 0) && vec_ready_i && !flush_i;
      if (flush_i) begin
         mq.delete();
         m_frz = 0;
      end else begin
         v    = pack_vec(wen_i, data_i);
         want = ev;
`ifdef PART_2_CAPTURE_CHANGE_ONLY_EN
         want = want && (!m_seen || v != m_last);
`endif
         if (do_pop) void'(mq.pop_front());
         if (want) begin
            if (mq.size() < DEPTH) begin
               mq.push_back('{vec: v, seq: 8'(m_seq)});
               m_seq  = (m_seq + 1) % 256;
               m_last = v;
               m_seen = 1;
            end else begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end
         end
         if (!m_frz && mq.size() >= HI) m_frz = 1;
         else if (m_frz && mq.size() <= LO) m_frz = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_model();
      chk("valid", 64'(vec_valid_o), 64'(mq.size() != 0));
      chk("level", 64'(level_o), 64'(mq.size()));
      chk("freeze", 64'(freeze_clk_o), 64'(m_frz));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
      if (mq.size() != 0) begin
         chk("vec_data", 64'(vec_data_o), 64'(mq[0].vec));
         chk("vec_seq", 64'(vec_seq_o), 64'(mq[0].seq));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      compare_model();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(vec_valid_o), 64'd0);
      chk({tag, "_data"}, 64'(vec_data_o), 64'd0);
      chk({tag, "_seq"}, 64'(vec_seq_o), 64'd0);
      chk({tag, "_level"}, 64'(level_o), 64'd0);
      chk({tag, "_freeze"}, 64'(freeze_clk_o), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
      chk({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
   endtask

   task automatic do_reset();
      rst_n_i     = 1'b0;
      clk_0_h     = 1'b0;
      vec_ready_i = 1'b0;
      flush_i     = 1'b0;
      #1;
      model_reset();
      chk_all_zero("reset");
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   // one clk_0_h pulse: high for two samples, low for two; push on the 3rd edge
   task automatic send_edge_d(input logic [2:0] w, input logic [23:0] d);
      wen_i   = w;
      data_i  = d;
      clk_0_h = 1'b1;
      tick();
      tick();
      clk_0_h = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_edge();
      uniq++;
      send_edge_d(3'(uniq), 24'(uniq) ^ 24'h5A0000);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        clk0;
      logic [2:0]  wen;
      logic [23:0] data;
      logic        ready;
      logic        exp_valid;
      logic [3:0]  exp_level;
      logic [26:0] exp_data;
      logic [7:0]  exp_seq;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int exp_frz[6];

      tbl[0] = '{1'b1, 3'b001, 24'h0000A5, 1'b0, 1'b0, 4'd0, 27'h0,   8'h0};
      tbl[1] = '{1'b1, 3'b001, 24'h0000A5, 1'b0, 1'b0, 4'd0, 27'h0,   8'h0};
      tbl[2] = '{1'b1, 3'b001, 24'h0000A5, 1'b0, 1'b1, 4'd1, 27'h1A5, 8'h0};
      tbl[3] = '{1'b1, 3'b001, 24'h0000A5, 1'b0, 1'b1, 4'd1, 27'h1A5, 8'h0};
      tbl[4] = '{1'b0, 3'b001, 24'h0000A5, 1'b0, 1'b1, 4'd1, 27'h1A5, 8'h0};
      tbl[5] = '{1'b0, 3'b001, 24'h0000A5, 1'b0, 1'b1, 4'd1, 27'h1A5, 8'h0};
      tbl[6] = '{1'b0, 3'b001, 24'h0000A5, 1'b1, 1'b0, 4'd0, 27'h0,   8'h0};
      exp_frz = '{1, 1, 1, 0, 0, 0};

      do_reset();

      // single edge, latency and packing
      for (int i = 0; i < 7; i++) begin
         clk_0_h     = tbl[i].clk0;
         wen_i       = tbl[i].wen;
         data_i      = tbl[i].data;
         vec_ready_i = tbl[i].ready;
         tick();
         chk("tbl_valid", 64'(vec_valid_o), 64'(tbl[i].exp_valid));
         chk("tbl_level", 64'(level_o), 64'(tbl[i].exp_level));
         if (tbl[i].exp_valid) begin
            chk("tbl_data", 64'(vec_data_o), 64'(tbl[i].exp_data));
            chk("tbl_seq", 64'(vec_seq_o), 64'(tbl[i].exp_seq));
         end
      end
      vec_ready_i = 1'b0;

      // backpressure and freeze hysteresis
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send_edge();
         if (i == 4) chk("frz_before_6th", 64'(freeze_clk_o), 64'd0);
      end
      chk("frz_after_6th", 64'(freeze_clk_o), 64'd1);
      chk("frz_level", 64'(level_o), 64'd6);
      vec_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("drain_seq", 64'(vec_seq_o), 64'(i));
         tick();
         chk("drain_level", 64'(level_o), 64'(5 - i));
         chk("drain_frz", 64'(freeze_clk_o), 64'(exp_frz[i]));
      end
      vec_ready_i = 1'b0;

      // overflow
      do_reset();
      for (int i = 0; i < 10; i++) send_edge();
      chk("ovf_level", 64'(level_o), 64'd8);
      chk("ovf_flag", 64'(overflow_o), 64'd1);
      chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
      vec_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain_seq", 64'(vec_seq_o), 64'(i));
         tick();
      end
      chk("ovf_empty", 64'(vec_valid_o), 64'd0);
      vec_ready_i = 1'b0;

      // push coinciding with pop at full
      do_reset();
      for (int i = 0; i < 8; i++) send_edge();
      wen_i   = 3'b111;
      data_i  = 24'hC0FFEE;
      clk_0_h = 1'b1;
      tick();
      tick();
      clk_0_h     = 1'b0;
      vec_ready_i = 1'b1;
      tick();
      vec_ready_i = 1'b0;
      chk("sim_level", 64'(level_o), 64'd8);
      chk("sim_ovf", 64'(overflow_o), 64'd0);
      chk("sim_head_seq", 64'(vec_seq_o), 64'd1);
      tick();

      // flush, including an edge landing on the flush cycle
      do_reset();
      for (int i = 0; i < 3; i++) send_edge();
      uniq++;
      data_i  = 24'(uniq);
      clk_0_h = 1'b1;
      tick();
      tick();
      clk_0_h = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_level", 64'(level_o), 64'd0);
      chk("flush_valid", 64'(vec_valid_o), 64'd0);
      chk("flush_frz", 64'(freeze_clk_o), 64'd0);
      chk("flush_ovf", 64'(overflow_o), 64'd0);
      tick();
      send_edge();
      chk("flush_next_seq", 64'(vec_seq_o), 64'd3);

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 10; i++) send_edge();
      chk("burst_frz", 64'(freeze_clk_o), 64'd1);
      chk("burst_drop", 64'(drop_cnt_o), 64'd3);
      clk_0_h = 1'b1;
      tick();
      #3;
      rst_n_i = 1'b0;
      #1;
      chk_all_zero("async_rst");
      do_reset();

`ifdef PART_2_CAPTURE_CHANGE_ONLY_EN
      // change-only capture
      for (int i = 0; i < 3; i++) send_edge_d(3'b001, 24'h0000A5);
      chk("chg_level", 64'(level_o), 64'd1);
      chk("chg_seq0", 64'(vec_seq_o), 64'd0);
      send_edge_d(3'b001, 24'h00005A);
      chk("chg_level2", 64'(level_o), 64'd2);
      vec_ready_i = 1'b1;
      tick();
      vec_ready_i = 1'b0;
      chk("chg_seq1", 64'(vec_seq_o), 64'd1);
      chk("chg_data1", 64'(vec_data_o), 64'h15A);
      do_reset();
`endif

      // randomized run against the model, three backpressure regimes
      for (int i = 0; i < 3000; i++) begin
         int phase;
         phase = i / 1000;
         if ($urandom_range(0, 2) == 0) clk_0_h = ~clk_0_h;
         case (phase)
            0:       vec_ready_i = ($urandom_range(0, 3) == 0);
            1:       vec_ready_i = ($urandom_range(0, 3) != 0);
            default: vec_ready_i = ($urandom_range(0, 1) == 0);
         endcase
         flush_i = ($urandom_range(0, 149) == 0);
         wen_i   = 3'($urandom_range(0, 1));
         data_i  = 24'($urandom_range(0, 3)) * 24'h010101;
         tick();
      end
      flush_i     = 1'b0;
      vec_ready_i = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
